// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared state encoding, byte-lane positions and depth default for
//            the instruction-memory loader. Option: IMEM_LOADER_CHKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int c_max_mem_depth_bit = 18;

    // Little-endian lanes: the first byte received lands in the lowest lane
    localparam int c_lane0_lsb = 0;
    localparam int c_lane1_lsb = 8;
    localparam int c_lane2_lsb = 16;
    localparam int c_lane3_lsb = 24;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
`ifdef IMEM_LOADER_CHKSUM_EN
        ,
        S_CHK  = 3'd5
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_asm.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_asm
// Brief    : Byte-to-word assembler; the assembled word and its ready strobe
//            are presented combinationally alongside the fourth byte.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

    always_comb begin
        o_word                   = '0;
        o_word[c_lane0_lsb +: 8] = r_shift[7:0];
        o_word[c_lane1_lsb +: 8] = r_shift[15:8];
        o_word[c_lane2_lsb +: 8] = r_shift[23:16];
        o_word[c_lane3_lsb +: 8] = i_byte;
    end

    assign o_word_ready = i_byte_en && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Loads a length-prefixed little-endian byte stream into IMEM while
//            holding the core. Option: IMEM_LOADER_CHKSUM_EN (trailing XOR byte).
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_MEM_WIDTH_LENGTH = 32,
    parameter int DATA_MEM_WIDTH_LENGTH = 32,
    parameter int MAX_MEM_DEPTH_BIT     = c_max_mem_depth_bit
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    output logic                             rx_ready,
    output logic                             we,
    output logic [ADDR_MEM_WIDTH_LENGTH-1:0] waddr,
    output logic [DATA_MEM_WIDTH_LENGTH-1:0] wdata,
    output logic                             cpu_hold,
    output logic                             done,
    output logic                             err
);

    localparam logic [32:0] c_depth_words = 33'd1 << MAX_MEM_DEPTH_BIT;
`ifdef IMEM_LOADER_CHKSUM_EN
    localparam state_t c_fin_state = S_CHK;
`else
    localparam state_t c_fin_state = S_DONE;
`endif

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic                             w_busy;
    logic                             w_start_ok;
    logic                             w_accept;
    logic                             w_asm_en;
    logic                             w_word_ready;
    logic                             w_last_word;
    logic [31:0]                      w_word;
    logic [31:0]                      r_n;
    logic [31:0]                      r_wcnt;
    logic                             r_we;
    logic [ADDR_MEM_WIDTH_LENGTH-1:0] r_waddr;
    logic [DATA_MEM_WIDTH_LENGTH-1:0] r_wdata;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]                       r_xor;
`endif

`ifdef IMEM_LOADER_CHKSUM_EN
    assign w_busy = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
`else
    assign w_busy = (r_state == S_LEN) || (r_state == S_DATA);
`endif
    assign w_start_ok  = start && !w_busy;
    assign w_accept    = rx_valid && w_busy;
    assign w_asm_en    = w_accept && ((r_state == S_LEN) || (r_state == S_DATA));
    assign w_last_word = (r_wcnt + 32'd1) == r_n;

    imem_loader_asm u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start_ok),
        .i_byte_en    (w_asm_en),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                if (w_word_ready) begin
                    if ({1'b0, w_word} > c_depth_words) w_state_nxt = S_ERR;
                    else if (w_word == 32'd0)           w_state_nxt = c_fin_state;
                    else                                w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_ready && w_last_word) w_state_nxt = c_fin_state;
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            S_CHK: begin
                if (w_accept) w_state_nxt = (rx_data == r_xor) ? S_DONE : S_ERR;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write port registers only move on a write so IMEM sees stable values otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_wcnt  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            r_xor   <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_n    <= '0;
                r_wcnt <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                r_xor  <= '0;
`endif
            end
            if ((r_state == S_LEN) && w_word_ready) r_n <= w_word;
`ifdef IMEM_LOADER_CHKSUM_EN
            if ((r_state == S_DATA) && w_accept) r_xor <= r_xor ^ rx_data;
`endif
            if ((r_state == S_DATA) && w_word_ready) begin
                r_we    <= 1'b1;
                r_waddr <= ADDR_MEM_WIDTH_LENGTH'(r_wcnt);
                r_wdata <= DATA_MEM_WIDTH_LENGTH'(w_word);
                r_wcnt  <= r_wcnt + 32'd1;
            end
        end
    end

    assign rx_ready = w_busy;
    assign cpu_hold = w_busy;
    assign done     = (r_state == S_DONE);
    assign err      = (r_state == S_ERR);
    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader.
//            Option: IMEM_LOADER_CHKSUM_EN (adds trailing checksum bytes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] c_prog[2] = '{32'h0000_0013, 32'h0010_0093};

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            q_addr.push_back(waddr);
            q_data.push_back(wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], int'($urandom_range(0, gapmax)));
    endtask

    // Two-word program: length 2, then the two instruction words
    task automatic send_prog(input int gapmax);
        send_word(32'd2, gapmax);
        send_word(c_prog[0], gapmax);
        send_word(c_prog[1], gapmax);
    endtask

    task automatic check_writes(input string tag, input int n_exp);
        check({tag, "_nwrites"}, 64'(q_addr.size()), 64'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            check({tag, "_addr"}, (i < q_addr.size()) ? 64'(q_addr[i]) : 64'hdead, 64'(i));
            check({tag, "_data"}, (i < q_data.size()) ? 64'(q_data[i]) : 64'hdead, 64'(c_prog[i]));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_we"},       64'(we),       64'd0);
        check({tag, "_waddr"},    64'(waddr),    64'd0);
        check({tag, "_wdata"},    64'(wdata),    64'd0);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_err"},      64'(err),      64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Basic two-word load, no gaps
        q_addr.delete(); q_data.delete();
        pulse_start();
        check("p1_hold_busy", 64'(cpu_hold), 64'd1);
        check("p1_ready_busy", 64'(rx_ready), 64'd1);
        send_prog(0);
`ifdef IMEM_LOADER_CHKSUM_EN
        check("p1_in_chk", 64'(rx_ready), 64'd1);
        send_byte(8'h90, 0);
`endif
        check("p1_done", 64'(done), 64'd1);
        @(negedge clk);
        check_writes("p1", 2);
        check("p1_hold_end", 64'(cpu_hold), 64'd0);
        check("p1_err", 64'(err), 64'd0);
        check("p1_ready_end", 64'(rx_ready), 64'd0);
        check("p1_waddr_hold", 64'(waddr), 64'd1);
        check("p1_wdata_hold", 64'(wdata), 64'h0010_0093);

        // Empty load: N = 0
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'd0, 0);
`ifdef IMEM_LOADER_CHKSUM_EN
        check("n0_in_chk", 64'(rx_ready), 64'd1);
        send_byte(8'h00, 0);
`endif
        check("n0_done", 64'(done), 64'd1);
        check("n0_hold", 64'(cpu_hold), 64'd0);
        @(negedge clk);
        check("n0_nwrites", 64'(q_addr.size()), 64'd0);

        // Oversized length aborts; ignores further bytes and extra starts are not needed
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'h0004_0001, 0);
        check("big_err", 64'(err), 64'd1);
        check("big_hold", 64'(cpu_hold), 64'd0);
        check("big_ready", 64'(rx_ready), 64'd0);
        check("big_done", 64'(done), 64'd0);
        send_word(32'h1122_3344, 0);
        check("big_err_sticky", 64'(err), 64'd1);
        check("big_ready_sticky", 64'(rx_ready), 64'd0);
        check("big_nwrites", 64'(q_addr.size()), 64'd0);

        // Exactly full depth is legal: enters DATA, then abandon via reset
        pulse_start();
        send_word(32'h0004_0000, 0);
        check("full_err", 64'(err), 64'd0);
        check("full_ready", 64'(rx_ready), 64'd1);
        pulse_rst();

        // Random stalls on the same program, with an ignored mid-load start
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'd2, 5);
        send_byte(8'h13, 2);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 3);
        send_byte(8'h00, 1);
        send_word(c_prog[1], 5);
`ifdef IMEM_LOADER_CHKSUM_EN
        send_byte(8'h90, 4);
`endif
        repeat (2) @(negedge clk);
        check_writes("gap", 2);
        check("gap_done", 64'(done), 64'd1);
        check("gap_hold", 64'(cpu_hold), 64'd0);

        // Reset after six data bytes drops the partial second word
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_word(32'd2, 0);
        send_word(c_prog[0], 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        check("mid_wdata_pre", 64'(wdata), 64'h13);
        pulse_rst();
        check_idle_outputs("mid_rst");
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        check("mid_nwrites", 64'(q_addr.size()), 64'd1);
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_prog(0);
`ifdef IMEM_LOADER_CHKSUM_EN
        send_byte(8'h90, 0);
`endif
        @(negedge clk);
        check_writes("reload", 2);
        check("reload_done", 64'(done), 64'd1);

`ifdef IMEM_LOADER_CHKSUM_EN
        // Wrong checksum: words stay written, load reported as failed
        q_addr.delete(); q_data.delete();
        pulse_start();
        send_prog(0);
        send_byte(8'h91, 0);
        check("bad_chk_err", 64'(err), 64'd1);
        check("bad_chk_done", 64'(done), 64'd0);
        check("bad_chk_hold", 64'(cpu_hold), 64'd0);
        @(negedge clk);
        check_writes("bad_chk", 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
